seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl_pkg.sv | 13 +
 rtl/seg_scan_ctrl_if.sv | 30 +++
 rtl/seg_scan_ctrl_decoder.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller:
// segment-bus constants and the scan FSM state encoding.
package seg_pkg;

    localparam int SEG_BITS = 7;
    localparam logic [SEG_BITS-1:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-transfer channel into the scan controller.
// valid/ready: a frame moves on a rising clock edge where frame_valid and frame_ready are both 1;
// the producer may drop frame_valid at any time, and then nothing is taken.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                      frame_valid;
    logic                      frame_ready;
    logic [4*NUM_DIGITS-1:0]   frame_data;
    logic [NUM_DIGITS-1:0]     frame_en;
    logic [NUM_DIGITS-1:0]     frame_dp;

    modport master (
        output frame_valid,
        output frame_data,
        output frame_en,
        output frame_dp,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_data,
        input  frame_en,
        input  frame_dp,
        output frame_ready
    );

endinterface

// File: rtl/seg_scan_ctrl_decoder.sv
// Hex nibble to active-low segment pattern, bit order {a,b,c,d,e,f,g}.
module seven_segment_display
    import seg_pkg::*;
(
    input  logic [3:0]          hex,
    output logic [SEG_BITS-1:0] seg_n
);

    always_comb begin
        seg_n = SEG_OFF;
        case (hex)
            4'h0: seg_n = 7'b0000001;
            4'h1: seg_n = 7'b1001111;
            4'h2: seg_n = 7'b0010010;
            4'h3: seg_n = 7'b0000110;
            4'h4: seg_n = 7'b1001100;
            4'h5: seg_n = 7'b0100100;
            4'h6: seg_n = 7'b0100000;
            4'h7: seg_n = 7'b0001111;
            4'h8: seg_n = 7'b0000000;
            4'h9: seg_n = 7'b0000100;
            4'hA: seg_n = 7'b0001000;
            4'hB: seg_n = 7'b1100000;
            4'hC: seg_n = 7'b0110001;
            4'hD: seg_n = 7'b1000010;
            4'hE: seg_n = 7'b0110000;
            4'hF: seg_n = 7'b0111000;
            default: seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered frame:
// new frames wait in the pending set and are committed only at a frame boundary.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seg_scan_ctrl_if.slave          frm,
    output logic [SEG_BITS-1:0]     seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_tick,
    output scan_state_t             dbg_state
);

    localparam int CNT_MAX0 = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int DW       = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_t            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, idx_inc;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   init_q, init_d;
    logic                   boundary;

    logic [DW-1:0]          act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]  act_en_q, act_en_d, pend_en_q, pend_en_d;
    logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                   pend_vld_q, pend_vld_d;

    logic [SEG_BITS-1:0]    seg_q, seg_d, dec_seg;
    logic                   dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]  anode_n_q, anode_n_d;
    logic                   tick_q, tick_d;
    logic [3:0]             dec_hex;

    // Decoder sees the digit that will be driven after this edge, so seg lines up with anode_n.
    assign dec_hex = act_data_d[{idx_d, 2'b00} +: 4];

    seven_segment_display u_dec (
        .hex   (dec_hex),
        .seg_n (dec_seg)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        init_d      = init_q;
        boundary    = 1'b0;
        act_data_d  = act_data_q;
        act_en_d    = act_en_q;
        act_dp_d    = act_dp_q;
        pend_data_d = pend_data_q;
        pend_en_d   = pend_en_q;
        pend_dp_d   = pend_dp_q;
        pend_vld_d  = pend_vld_q;
        idx_inc     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        case (state_q)
            BLANK: begin
                // With no gap configured, only the post-reset BLANK is ever visited, for one cycle.
                if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                    state_d  = DRIVE;
                    idx_d    = idx_inc;
                    cnt_d    = '0;
                    boundary = init_q;
                    init_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d    = '0;
                    boundary = (idx_q == IDX_LAST);
                    if (BLANK_CYCLES == 0) begin
                        idx_d = idx_inc;
                    end else begin
                        state_d = BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase

        // Commit and accept are exclusive: accept needs pend_vld low, commit needs it high.
        if (boundary && pend_vld_q) begin
            act_data_d = pend_data_q;
            act_en_d   = pend_en_q;
            act_dp_d   = pend_dp_q;
            pend_vld_d = 1'b0;
        end else if (frm.frame_valid && !pend_vld_q) begin
            pend_data_d = frm.frame_data;
            pend_en_d   = frm.frame_en;
            pend_dp_d   = frm.frame_dp;
            pend_vld_d  = 1'b1;
        end

        anode_n_d = '1;
        seg_d     = SEG_OFF;
        dp_n_d    = 1'b1;
        tick_d    = boundary;
        if (state_d == DRIVE) begin
            dp_n_d = !act_dp_d[idx_d];
            if (act_en_d[idx_d]) begin
                anode_n_d[idx_d] = 1'b0;
                seg_d            = dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            idx_q       <= IDX_LAST;
            cnt_q       <= '0;
            init_q      <= 1'b1;
            act_data_q  <= '0;
            act_en_q    <= '0;
            act_dp_q    <= '0;
            pend_data_q <= '0;
            pend_en_q   <= '0;
            pend_dp_q   <= '0;
            pend_vld_q  <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_n_q      <= 1'b1;
            anode_n_q   <= '1;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            init_q      <= init_d;
            act_data_q  <= act_data_d;
            act_en_q    <= act_en_d;
            act_dp_q    <= act_dp_d;
            pend_data_q <= pend_data_d;
            pend_en_q   <= pend_en_d;
            pend_dp_q   <= pend_dp_d;
            pend_vld_q  <= pend_vld_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
            anode_n_q   <= anode_n_d;
            tick_q      <= tick_d;
        end
    end

    assign frm.frame_ready = !pend_vld_q;
    assign seg             = seg_q;
    assign dp_n            = dp_n_q;
    assign anode_n         = anode_n_q;
    assign frame_tick      = tick_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a BLANK_CYCLES=2 instance and a BLANK_CYCLES=0 instance
// on a shared clock and reset, with hand-computed segment patterns and tick spacing.
module tb_seg_scan_ctrl;

    localparam logic [6:0] S1  = 7'b1001111;
    localparam logic [6:0] S2  = 7'b0010010;
    localparam logic [6:0] S3  = 7'b0000110;
    localparam logic [6:0] S4  = 7'b1001100;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] SD  = 7'b1000010;
    localparam logic [6:0] OFF = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(4)) fa ();
    seg_scan_ctrl_if #(.NUM_DIGITS(4)) fb ();

    logic [6:0]           seg_a, seg_b;
    logic                 dp_a, dp_b, tick_a, tick_b;
    logic [3:0]           an_a, an_b;
    seg_pkg::scan_state_t st_a, st_b;

    seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .frm(fa.slave), .seg(seg_a), .dp_n(dp_a),
        .anode_n(an_a), .frame_tick(tick_a), .dbg_state(st_a)
    );

    seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(8), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .frm(fb.slave), .seg(seg_b), .dp_n(dp_b),
        .anode_n(an_b), .frame_tick(tick_b), .dbg_state(st_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n;
    int ok;
    int an2_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input bit use_b, input string tag, input logic [3:0] an,
                           input logic [6:0] sg, input logic dp);
        chk({tag, "_anode"}, use_b ? an_b : an_a, an);
        chk({tag, "_seg"},   use_b ? seg_b : seg_a, sg);
        chk({tag, "_dp"},    use_b ? dp_b : dp_a, dp);
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Returns the number of cycles until frame_tick is seen high, or -1 on timeout.
    task automatic wait_tick(input bit use_b, input int limit, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = -1;
        for (int i = 1; i <= limit && !seen; i++) begin
            @(negedge clk);
            if ((use_b ? tick_b : tick_a) === 1'b1) begin
                seen   = 1'b1;
                cycles = i;
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        fa.frame_valid = 1'b0;
        fa.frame_data  = '0;
        fa.frame_en    = '0;
        fa.frame_dp    = '0;
        fb.frame_valid = 1'b0;
        fb.frame_data  = '0;
        fb.frame_en    = '0;
        fb.frame_dp    = '0;

        // Reset state
        step(3);
        chk_out(1'b0, "rst", 4'hF, OFF, 1'b1);
        chk("rst_ready", fa.frame_ready, 1);
        chk("rst_tick", tick_a, 0);
        chk("rst_state", st_a, seg_pkg::BLANK);
        chk("rst_b_anode", an_b, 4'hF);

        // Basic frame, committed at the initial boundary
        rst_n          = 1'b1;
        fa.frame_valid = 1'b1;
        fa.frame_data  = 16'h1234;
        fa.frame_en    = 4'hF;
        fa.frame_dp    = 4'b0001;
        chk("idle_ready", fa.frame_ready, 1);
        step(1);
        fa.frame_valid = 1'b0;
        chk("xfer_ready", fa.frame_ready, 0);
        chk("pre_commit_anode", an_a, 4'hF);
        step(1);
        chk("init_tick", tick_a, 1);
        chk("commit_ready", fa.frame_ready, 1);
        chk_out(1'b0, "d0", 4'b1110, S4, 1'b0);
        ok = 0;
        for (int i = 1; i < 8; i++) begin
            step(1);
            if (an_a === 4'b1110 && seg_a === S4 && dp_a === 1'b0 && tick_a === 1'b0) ok++;
        end
        chk("d0_dwell", ok, 7);
        step(1);
        chk_out(1'b0, "gap0", 4'hF, OFF, 1'b1);
        step(1);
        chk_out(1'b0, "gap1", 4'hF, OFF, 1'b1);
        step(1);
        chk_out(1'b0, "d1", 4'b1101, S3, 1'b1);
        wait_tick(1'b0, 60, n);
        chk("first_period", n, 28);
        wait_tick(1'b0, 60, n);
        chk("tick_period", n, 40);

        // No tearing: second frame accepted mid-frame, third held off
        step(5);
        fa.frame_valid = 1'b1;
        fa.frame_data  = 16'hABCD;
        fa.frame_en    = 4'hF;
        fa.frame_dp    = 4'b0000;
        chk("mid_ready", fa.frame_ready, 1);
        step(1);
        chk("mid_accept", fa.frame_ready, 0);
        fa.frame_data  = 16'h5678;
        fa.frame_dp    = 4'hF;
        step(9);
        chk_out(1'b0, "old_d1", 4'b1101, S3, 1'b1);
        step(10);
        chk_out(1'b0, "old_d2", 4'b1011, S2, 1'b1);
        step(10);
        chk_out(1'b0, "old_d3", 4'b0111, S1, 1'b1);
        chk("hold_ready", fa.frame_ready, 0);
        step(4);
        chk("edge_ready", fa.frame_ready, 0);
        chk("edge_tick", tick_a, 0);
        step(1);
        chk("swap_tick", tick_a, 1);
        chk("swap_ready", fa.frame_ready, 1);
        step(1);
        chk("third_accept", fa.frame_ready, 0);
        fa.frame_valid = 1'b0;
        step(1);
        chk_out(1'b0, "new_d0", 4'b1110, SD, 1'b1);
        wait_tick(1'b0, 60, n);
        chk("swap_period", n, 38);
        step(2);
        chk_out(1'b0, "third_d0", 4'b1110, S8, 1'b0);

        // Disabled digit 2
        fa.frame_valid = 1'b1;
        fa.frame_data  = 16'h1234;
        fa.frame_en    = 4'b1011;
        fa.frame_dp    = 4'b0000;
        step(1);
        fa.frame_valid = 1'b0;
        chk("dis_accept", fa.frame_ready, 0);
        wait_tick(1'b0, 60, n);
        chk("dis_commit_wait", n, 37);
        an2_low = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (an_a[2] === 1'b0) an2_low++;
            if (i == 12) chk_out(1'b0, "dis_d1", 4'b1101, S3, 1'b1);
            if (i == 22) chk_out(1'b0, "dis_d2", 4'hF, OFF, 1'b1);
        end
        chk("dis_an2_low", an2_low, 0);
        chk("dis_period", tick_a, 1);

        // Reset mid-DRIVE with a frame pending
        fa.frame_valid = 1'b1;
        fa.frame_data  = 16'h9999;
        fa.frame_en    = 4'hF;
        fa.frame_dp    = 4'hF;
        step(1);
        fa.frame_valid = 1'b0;
        chk("rst_pend", fa.frame_ready, 0);
        step(4);
        chk_out(1'b0, "pre_rst", 4'b1110, S4, 1'b1);
        rst_n = 1'b0;
        step(1);
        chk_out(1'b0, "mid_rst", 4'hF, OFF, 1'b1);
        chk("mid_rst_ready", fa.frame_ready, 1);
        chk("mid_rst_tick", tick_a, 0);
        chk("mid_rst_state", st_a, seg_pkg::BLANK);
        rst_n = 1'b1;
        step(2);
        chk("rel_tick", tick_a, 1);
        chk_out(1'b0, "rel_blank", 4'hF, OFF, 1'b1);
        wait_tick(1'b0, 60, n);
        chk("rel_period", n, 38);
        step(2);
        chk_out(1'b0, "discarded", 4'hF, OFF, 1'b1);

        // BLANK_CYCLES = 0 variant
        rst_n = 1'b0;
        step(2);
        rst_n          = 1'b1;
        fb.frame_valid = 1'b1;
        fb.frame_data  = 16'h1234;
        fb.frame_en    = 4'hF;
        fb.frame_dp    = 4'b0001;
        step(1);
        fb.frame_valid = 1'b0;
        chk("b_init_tick", tick_b, 1);
        chk("b_init_ready", fb.frame_ready, 0);
        chk_out(1'b1, "b_init", 4'hF, OFF, 1'b1);
        wait_tick(1'b1, 60, n);
        chk("b_first_period", n, 32);
        chk_out(1'b1, "b_d0", 4'b1110, S4, 1'b0);
        step(7);
        chk_out(1'b1, "b_d0_last", 4'b1110, S4, 1'b0);
        step(1);
        chk_out(1'b1, "b_d1", 4'b1101, S3, 1'b1);
        wait_tick(1'b1, 60, n);
        chk("b_period", n, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
